// File: rtl/rtc_time_counter.sv
// Cascaded sub/sec/min/hour time-of-day and countdown counter with a clock-rate
// prescaler, validated parallel load, per-field carry ticks and a sticky done flag.
module rtc_time_counter #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int TICK_HZ     = 1000,
    parameter int HOURS_MOD   = 24,
    parameter int SUB_W       = 10,
    parameter int HOUR_W      = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reconfig_en,
    input  logic              run,
    input  logic              dir,
    input  logic              load,
    input  logic [SUB_W-1:0]  load_sub,
    input  logic [5:0]        load_sec,
    input  logic [5:0]        load_min,
    input  logic [HOUR_W-1:0] load_hour,
    output logic [SUB_W-1:0]  sub,
    output logic [5:0]        sec,
    output logic [5:0]        min,
    output logic [HOUR_W-1:0] hour,
    output logic              tick_sub,
    output logic              tick_sec,
    output logic              tick_min,
    output logic              load_err,
    output logic              done
);

    localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);

    localparam logic [PW-1:0]     PRESC_MAX = PW'(DIV - 1);
    localparam logic [SUB_W-1:0]  SUB_MAX   = SUB_W'(TICK_HZ - 1);
    localparam logic [5:0]        SEC_MAX   = 6'd59;
    localparam logic [HOUR_W-1:0] HOUR_MAX  = HOUR_W'(HOURS_MOD - 1);

    logic [PW-1:0]     presc, presc_d;
    logic [SUB_W-1:0]  sub_d;
    logic [5:0]        sec_d, min_d;
    logic [HOUR_W-1:0] hour_d;
    logic              tick_sub_d, tick_sec_d, tick_min_d, load_err_d, done_d;
    logic              load_ok, subtick, all_zero;

    assign load_ok  = (load_sub <= SUB_MAX) && (load_sec <= SEC_MAX) &&
                      (load_min <= SEC_MAX) && (load_hour <= HOUR_MAX);
    assign subtick  = run && !done && (presc == PRESC_MAX);
    assign all_zero = (sub == '0) && (sec == '0) && (min == '0) && (hour == '0);

    always_comb begin
        // NOTE: every variable gets a default before any branch so no path leaves it unassigned (no latch).
        presc_d    = presc;
        sub_d      = sub;
        sec_d      = sec;
        min_d      = min;
        hour_d     = hour;
        tick_sub_d = 1'b0;
        tick_sec_d = 1'b0;
        tick_min_d = 1'b0;
        load_err_d = 1'b0;
        done_d     = done;

        if (reconfig_en) begin
            presc_d = '0;
            sub_d   = '0;
            sec_d   = '0;
            min_d   = '0;
            hour_d  = '0;
            done_d  = 1'b0;
        end else if (load) begin
            // A load always pre-empts a coincident subtick; a rejected load changes nothing.
            if (load_ok) begin
                presc_d = '0;
                sub_d   = load_sub;
                sec_d   = load_sec;
                min_d   = load_min;
                hour_d  = load_hour;
                done_d  = 1'b0;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (run && !done) begin
            presc_d = subtick ? '0 : presc + PW'(1);
            if (subtick && !dir) begin
                tick_sub_d = 1'b1;
                sub_d      = (sub == SUB_MAX) ? '0 : sub + SUB_W'(1);
                if (sub == SUB_MAX) begin
                    tick_sec_d = 1'b1;
                    sec_d      = (sec == SEC_MAX) ? '0 : sec + 6'd1;
                    if (sec == SEC_MAX) begin
                        tick_min_d = 1'b1;
                        min_d      = (min == SEC_MAX) ? '0 : min + 6'd1;
                        if (min == SEC_MAX)
                            hour_d = (hour == HOUR_MAX) ? '0 : hour + HOUR_W'(1);
                    end
                end
            end else if (subtick && all_zero) begin
                done_d = 1'b1;
            end else if (subtick) begin
                // Borrow never reaches hour==0 here: that would mean all fields were zero.
                tick_sub_d = 1'b1;
                sub_d      = (sub == '0) ? SUB_MAX : sub - SUB_W'(1);
                if (sub == '0) begin
                    tick_sec_d = 1'b1;
                    sec_d      = (sec == '0) ? SEC_MAX : sec - 6'd1;
                    if (sec == '0) begin
                        tick_min_d = 1'b1;
                        min_d      = (min == '0) ? SEC_MAX : min - 6'd1;
                        if (min == '0)
                            hour_d = hour - HOUR_W'(1);
                    end
                end
                if ((sub_d == '0) && (sec_d == '0) && (min_d == '0) && (hour_d == '0))
                    done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            presc    <= '0;
            sub      <= '0;
            sec      <= '0;
            min      <= '0;
            hour     <= '0;
            tick_sub <= 1'b0;
            tick_sec <= 1'b0;
            tick_min <= 1'b0;
            load_err <= 1'b0;
            done     <= 1'b0;
        end else begin
            presc    <= presc_d;
            sub      <= sub_d;
            sec      <= sec_d;
            min      <= min_d;
            hour     <= hour_d;
            tick_sub <= tick_sub_d;
            tick_sec <= tick_sec_d;
            tick_min <= tick_min_d;
            load_err <= load_err_d;
            done     <= done_d;
        end
    end

endmodule

// File: tb/tb_rtc_time_counter.sv
// Self-checking bench for rtc_time_counter: directed scenarios with literal
// expectations, then randomized stimulus against a total-count time model.
module tb_rtc_time_counter;

    localparam int CLK_FREQ_HZ = 20;
    localparam int TICK_HZ     = 10;
    localparam int HOURS_MOD   = 24;
    localparam int SUB_W       = 4;
    localparam int HOUR_W      = 5;
    localparam int DIV         = CLK_FREQ_HZ / TICK_HZ;
    localparam int DAY         = HOURS_MOD * 3600 * TICK_HZ;

    logic              clk;
    logic              reset, reconfig_en, run, dir, load;
    logic [SUB_W-1:0]  load_sub;
    logic [5:0]        load_sec, load_min;
    logic [HOUR_W-1:0] load_hour;
    logic [SUB_W-1:0]  sub;
    logic [5:0]        sec, min;
    logic [HOUR_W-1:0] hour;
    logic              tick_sub, tick_sec, tick_min, load_err, done;

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;

    // Model: the whole time value as one count of sub-second ticks.
    int m_total = 0;
    int m_phase = 0;
    bit m_done = 0, m_tsub = 0, m_tsec = 0, m_tmin = 0, m_lerr = 0;

    rtc_time_counter #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ), .TICK_HZ(TICK_HZ), .HOURS_MOD(HOURS_MOD),
        .SUB_W(SUB_W), .HOUR_W(HOUR_W)
    ) dut (
        .clk(clk), .reset(reset), .reconfig_en(reconfig_en), .run(run), .dir(dir),
        .load(load), .load_sub(load_sub), .load_sec(load_sec), .load_min(load_min),
        .load_hour(load_hour), .sub(sub), .sec(sec), .min(min), .hour(hour),
        .tick_sub(tick_sub), .tick_sec(tick_sec), .tick_min(tick_min),
        .load_err(load_err), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int f_sub(input int t);  return t % TICK_HZ;               endfunction
    function automatic int f_sec(input int t);  return (t / TICK_HZ) % 60;        endfunction
    function automatic int f_min(input int t);  return (t / (TICK_HZ * 60)) % 60; endfunction
    function automatic int f_hour(input int t); return t / (TICK_HZ * 3600);      endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model
        int old;
        m_tsub = 0;
        m_tsec = 0;
        m_tmin = 0;
        m_lerr = 0;
        if (reset || reconfig_en) begin
            m_total = 0;
            m_phase = 0;
            m_done  = 0;
        end else if (load) begin
            if (int'(load_sub) < TICK_HZ && int'(load_sec) < 60 &&
                int'(load_min) < 60 && int'(load_hour) < HOURS_MOD) begin
                m_total = ((int'(load_hour) * 60 + int'(load_min)) * 60 + int'(load_sec))
                          * TICK_HZ + int'(load_sub);
                m_phase = 0;
                m_done  = 0;
            end else begin
                m_lerr = 1;
            end
        end else if (run && !m_done) begin
            if (m_phase == DIV - 1) begin
                m_phase = 0;
                old = m_total;
                if (!dir) m_total = (m_total + 1) % DAY;
                else if (m_total > 0) m_total = m_total - 1;
                if (dir && m_total == 0) m_done = 1;
                if (m_total != old) begin
                    m_tsub = 1;
                    m_tsec = f_sec(old) != f_sec(m_total);
                    m_tmin = f_min(old) != f_min(m_total);
                end
            end else begin
                m_phase = m_phase + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("sub",      32'(sub),      f_sub(m_total));
            check("sec",      32'(sec),      f_sec(m_total));
            check("min",      32'(min),      f_min(m_total));
            check("hour",     32'(hour),     f_hour(m_total));
            check("tick_sub", 32'(tick_sub), 32'(m_tsub));
            check("tick_sec", 32'(tick_sec), 32'(m_tsec));
            check("tick_min", 32'(tick_min), 32'(m_tmin));
            check("load_err", 32'(load_err), 32'(m_lerr));
            check("done",     32'(done),     32'(m_done));
        end
    end

    // Called just after a falling edge; returns at the falling edge after the load was sampled.
    task automatic do_load(input int s, input int se, input int m, input int h);
        load      = 1'b1;
        load_sub  = SUB_W'(s);
        load_sec  = 6'(se);
        load_min  = 6'(m);
        load_hour = HOUR_W'(h);
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        reset = 1'b1; reconfig_en = 1'b0; run = 1'b0; dir = 1'b0; load = 1'b0;
        load_sub = '0; load_sec = '0; load_min = '0; load_hour = '0;

        @(negedge clk);
        chk_en = 1;
        check("rst_sub", 32'(sub), 0);
        check("rst_hour", 32'(hour), 0);
        check("rst_done", 32'(done), 0);
        check("rst_tick_sub", 32'(tick_sub), 0);

        // First subtick two cycles after run; sub carry into sec.
        reset = 1'b0; run = 1'b1; dir = 1'b0;
        @(negedge clk);
        check("first_tick_early", 32'(tick_sub), 0);
        @(negedge clk);
        check("first_tick", 32'(tick_sub), 1);
        check("first_sub", 32'(sub), 1);
        repeat (18) @(negedge clk);
        check("carry_sub", 32'(sub), 0);
        check("carry_sec", 32'(sec), 1);
        check("carry_tick_sub", 32'(tick_sub), 1);
        check("carry_tick_sec", 32'(tick_sec), 1);

        // Full-day rollover.
        do_load(9, 59, 59, 23);
        check("roll_loaded_hour", 32'(hour), 23);
        @(negedge clk);
        check("roll_no_tick_yet", 32'(tick_sub), 0);
        @(negedge clk);
        check("roll_sub", 32'(sub), 0);
        check("roll_sec", 32'(sec), 0);
        check("roll_min", 32'(min), 0);
        check("roll_hour", 32'(hour), 0);
        check("roll_tick_min", 32'(tick_min), 1);
        check("roll_tick_sec", 32'(tick_sec), 1);
        @(negedge clk);
        check("roll_tick_min_once", 32'(tick_min), 0);

        // Countdown to zero, then frozen.
        dir = 1'b1;
        do_load(1, 0, 0, 0);
        repeat (2) @(negedge clk);
        check("cd_done", 32'(done), 1);
        check("cd_sub", 32'(sub), 0);
        check("cd_tick_sub", 32'(tick_sub), 1);
        repeat (10) @(negedge clk);
        check("cd_frozen_done", 32'(done), 1);
        check("cd_frozen_tick", 32'(tick_sub), 0);

        // Rejected loads, then an accepted one.
        do_load(0, 60, 0, 0);
        check("bad_sec_err", 32'(load_err), 1);
        check("bad_sec_done", 32'(done), 1);
        check("bad_sec_sec", 32'(sec), 0);
        @(negedge clk);
        check("bad_sec_err_pulse", 32'(load_err), 0);
        do_load(0, 0, 0, 24);
        check("bad_hour_err", 32'(load_err), 1);
        do_load(0, 5, 0, 0);
        check("good_sec", 32'(sec), 5);
        check("good_done", 32'(done), 0);
        check("good_err", 32'(load_err), 0);

        // reconfig_en mid-count.
        dir = 1'b0;
        repeat (3) @(negedge clk);
        reconfig_en = 1'b1;
        @(negedge clk);
        reconfig_en = 1'b0;
        check("rcfg_sec", 32'(sec), 0);
        check("rcfg_sub", 32'(sub), 0);
        @(negedge clk);
        check("rcfg_no_tick", 32'(tick_sub), 0);
        @(negedge clk);
        check("rcfg_tick", 32'(tick_sub), 1);
        check("rcfg_sub1", 32'(sub), 1);

        // run pattern 1,0,0,0,1 delays the subtick by three cycles.
        @(negedge clk);
        run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("pause_no_tick", 32'(tick_sub), 0);
        end
        run = 1'b1;
        @(negedge clk);
        check("pause_tick", 32'(tick_sub), 1);
        check("pause_sub", 32'(sub), 2);

        // Load coincident with a subtick.
        @(negedge clk);
        do_load(3, 4, 5, 6);
        check("ldtick_sub", 32'(sub), 3);
        check("ldtick_min", 32'(min), 5);
        check("ldtick_no_tick", 32'(tick_sub), 0);

        // Randomized phase.
        for (int i = 0; i < 4000; i++) begin
            int mode;
            reset       = ($urandom_range(0, 299) == 0);
            reconfig_en = ($urandom_range(0, 149) == 0);
            run         = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 29) == 0) dir = ~dir;
            load = ($urandom_range(0, 39) == 0);
            mode = $urandom_range(0, 9);
            if (mode == 0) begin
                load_sub  = SUB_W'($urandom_range(0, 15));
                load_sec  = 6'($urandom_range(0, 63));
                load_min  = 6'($urandom_range(0, 63));
                load_hour = HOUR_W'($urandom_range(0, 31));
            end else if (mode < 4) begin
                load_sub  = SUB_W'($urandom_range(5, 9));
                load_sec  = 6'd59;
                load_min  = 6'd59;
                load_hour = HOUR_W'(23);
            end else if (mode < 7) begin
                load_sub  = SUB_W'($urandom_range(0, 9));
                load_sec  = 6'($urandom_range(0, 1));
                load_min  = 6'd0;
                load_hour = HOUR_W'($urandom_range(0, 1));
            end else begin
                load_sub  = SUB_W'($urandom_range(0, 9));
                load_sec  = 6'($urandom_range(0, 59));
                load_min  = 6'($urandom_range(0, 59));
                load_hour = HOUR_W'($urandom_range(0, 23));
            end
            @(negedge clk);
        end

        reset = 1'b0; reconfig_en = 1'b0; load = 1'b0; run = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
